serial_frame_deserializer: RTL and testbench

//  Consumer for the universal shift register's serial output (S_OUTcond / S_OUTstruct).

---
 rtl/serial_frame_deserializer_pkg.sv | 18 +
 rtl/bit_trans_counter.sv | 33 +++
 rtl/serial_frame_deserializer.sv | 138 +++++++++++++
 tb/tb_serial_frame_deserializer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_deserializer_pkg.sv
// Shared definitions for the serial frame deserializer: default geometry,
// default sync pattern and the FSM state encoding.
package serial_frame_deserializer_pkg;

    localparam int                  DEF_WIDTH   = 4;
    localparam int                  DEF_NIBBLES = 2;
    localparam int                  DEF_CNTW    = 16;
    localparam logic [DEF_WIDTH-1:0] DEF_SYNC   = 4'b1101;

    // state   | meaning
    // ST_HUNT | searching the qualified bit stream for the sync nibble
    // ST_DATA | sync seen; collecting frame bits in the latched bit order
    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

endpackage

// File: rtl/bit_trans_counter.sv
// Saturating counter of value changes between consecutive qualified bits on
// a serial line. The first qualified bit after reset only primes the history.
module bit_trans_counter #(
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RESET_L,
    input  logic            ENB,
    input  logic            S_IN,
    output logic [CNTW-1:0] TRANS_CNT
);

    logic            prev_bit;
    logic            prev_vld;
    logic [CNTW-1:0] cnt;

    // Track the previous qualified bit and count changes, holding at all-ones.
    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            prev_bit <= 1'b0;
            prev_vld <= 1'b0;
            cnt      <= '0;
        end else if (ENB) begin
            prev_bit <= S_IN;
            prev_vld <= 1'b1;
            if (prev_vld && (S_IN != prev_bit) && !(&cnt))
                cnt <= cnt + 1'b1;
        end
    end

    assign TRANS_CNT = cnt;

endmodule

// File: rtl/serial_frame_deserializer.sv
// Hunts a qualified serial stream for a sync nibble, assembles the following
// NIBBLES nibbles into one frame and offers it on a VALID/READY handshake.
// A frame that completes while an unconsumed one is still held is dropped and
// flagged on the sticky OVERRUN output.
//
// state   | meaning
// ST_HUNT | shifting bits through the sync window using live DIR
// ST_DATA | LOCKED; shifting frame bits using the DIR latched at sync
module serial_frame_deserializer
    import serial_frame_deserializer_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC    = DEF_SYNC,
    parameter int               NIBBLES = DEF_NIBBLES,
    parameter int               CNTW    = DEF_CNTW
) (
    input  logic                     CLK,
    input  logic                     RESET_L,
    input  logic                     ENB,
    input  logic                     S_IN,
    input  logic                     DIR,
    input  logic                     READY,
    output logic [WIDTH*NIBBLES-1:0] Q,
    output logic                     VALID,
    output logic                     LOCKED,
    output logic                     OVERRUN,
    output logic [CNTW-1:0]          TRANS_CNT
);

    localparam int F      = WIDTH * NIBBLES;
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int BCNT_W = (F > 1) ? $clog2(F) : 1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    win_q, win_d, win_shift;
    logic [FILL_W-1:0]   fill_q, fill_d, fill_inc;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [F-1:0]        sh_q, sh_d, sh_shift;
    logic                dir_q, dir_d;
    logic [F-1:0]        q_q, q_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    // Candidate next values for the window (live DIR) and frame (latched DIR).
    assign win_shift = DIR   ? {S_IN, win_q[WIDTH-1:1]} : {win_q[WIDTH-2:0], S_IN};
    assign sh_shift  = dir_q ? {S_IN, sh_q[F-1:1]}      : {sh_q[F-2:0], S_IN};
    assign fill_inc  = (fill_q == FILL_W'(WIDTH)) ? fill_q : fill_q + 1'b1;

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_q   <= ST_HUNT;
            win_q     <= '0;
            fill_q    <= '0;
            bcnt_q    <= '0;
            sh_q      <= '0;
            dir_q     <= 1'b0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            bcnt_q    <= bcnt_d;
            sh_q      <= sh_d;
            dir_q     <= dir_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state, frame assembly and handshake logic.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        fill_d    = fill_q;
        bcnt_d    = bcnt_q;
        sh_d      = sh_q;
        dir_d     = dir_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        // Consumption first; a frame loading on the same edge re-asserts VALID.
        if (valid_q && READY)
            valid_d = 1'b0;

        if (ENB) begin
            case (state_q)
                ST_HUNT: begin
                    win_d  = win_shift;
                    fill_d = fill_inc;
                    if ((fill_inc == FILL_W'(WIDTH)) && (win_shift == SYNC)) begin
                        state_d = ST_DATA;
                        dir_d   = DIR;
                        bcnt_d  = '0;
                        win_d   = '0;
                    end
                end
                ST_DATA: begin
                    sh_d   = sh_shift;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BCNT_W'(F - 1)) begin
                        // Frame complete: every frame must be preceded by a fresh sync.
                        state_d = ST_HUNT;
                        fill_d  = '0;
                        bcnt_d  = '0;
                        if (!valid_q || READY) begin
                            q_d     = sh_shift;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    bit_trans_counter #(
        .CNTW (CNTW)
    ) u_trans (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .ENB       (ENB),
        .S_IN      (S_IN),
        .TRANS_CNT (TRANS_CNT)
    );

    assign Q       = q_q;
    assign VALID   = valid_q;
    assign LOCKED  = (state_q == ST_DATA);
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer with a behavioural reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_serial_frame_deserializer;

    logic        CLK = 1'b0;
    logic        RESET_L, ENB, S_IN, DIR, READY;
    logic [7:0]  Q;
    logic        VALID, LOCKED, OVERRUN;
    logic [15:0] TRANS_CNT;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    serial_frame_deserializer dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .ENB       (ENB),
        .S_IN      (S_IN),
        .DIR       (DIR),
        .READY     (READY),
        .Q         (Q),
        .VALID     (VALID),
        .LOCKED    (LOCKED),
        .OVERRUN   (OVERRUN),
        .TRANS_CNT (TRANS_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_locked, m_dir, m_valid, m_ovr;
    int       m_win, m_fill, m_prev, m_trans;
    bit [7:0] m_q;
    bit       m_bits[$];

    always @(posedge CLK) begin
        bit load;
        int frame;
        load = 1'b0;
        if (!RESET_L) begin
            m_locked = 0; m_dir = 0; m_valid = 0; m_ovr = 0;
            m_win = 0; m_fill = 0; m_prev = -1; m_trans = 0; m_q = 0;
            m_bits.delete();
        end else begin
            if (ENB) begin
                if (m_prev >= 0 && m_prev != int'(S_IN) && m_trans < 65535) m_trans++;
                m_prev = int'(S_IN);
                if (!m_locked) begin
                    m_win  = DIR ? (m_win / 2 + int'(S_IN) * 8) : ((m_win * 2 + int'(S_IN)) % 16);
                    m_fill = (m_fill < 4) ? m_fill + 1 : 4;
                    if (m_fill == 4 && m_win == 13) begin
                        m_locked = 1; m_dir = DIR; m_win = 0; m_bits.delete();
                    end
                end else begin
                    m_bits.push_back(S_IN);
                    if (m_bits.size() == 8) begin
                        frame = 0;
                        for (int i = 0; i < 8; i++)
                            frame += int'(m_bits[i]) << (m_dir ? i : 7 - i);
                        m_locked = 0; m_fill = 0; m_win = 0;
                        m_bits.delete();
                        if (!m_valid || READY) begin
                            m_q = frame[7:0]; load = 1'b1;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            end
            if (load) m_valid = 1;
            else if (m_valid && READY) m_valid = 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_q",       32'(Q),         32'(m_q));
            chk("m_valid",   32'(VALID),     32'(m_valid));
            chk("m_locked",  32'(LOCKED),    32'(m_locked));
            chk("m_overrun", 32'(OVERRUN),   32'(m_ovr));
            chk("m_trans",   32'(TRANS_CNT), 32'(m_trans));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b);
        ENB = 1'b1; S_IN = b;
        @(negedge CLK);
        ENB = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        ENB = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [7:0]  d3;
        logic [11:0] s5;
        RESET_L = 0; ENB = 1; S_IN = 0; DIR = 0; READY = 1;

        // 1: reset with live traffic
        repeat (2) begin @(negedge CLK); S_IN = ~S_IN; end
        cmp_en = 1'b1;
        chk("rst_q", 32'(Q), 0); chk("rst_valid", 32'(VALID), 0);
        chk("rst_locked", 32'(LOCKED), 0); chk("rst_overrun", 32'(OVERRUN), 0);
        chk("rst_trans", 32'(TRANS_CNT), 0);
        RESET_L = 1; ENB = 0;
        idle(1);

        // 2: MSB-first frame
        DIR = 0;
        send_nib(4'b1101);
        chk("t2_locked", 32'(LOCKED), 1);
        send_nib(4'hA); send_nib(4'h6);
        chk("t2_q", 32'(Q), 32'hA6); chk("t2_valid", 32'(VALID), 1);
        idle(1);
        chk("t2_valid_drop", 32'(VALID), 0);

        // 3: LSB-first frame, DIR toggled while in DATA
        DIR = 1;
        send_nib(4'b1011);
        chk("t3_locked", 32'(LOCKED), 1);
        d3 = 8'b0110_0101;
        for (int i = 7; i >= 0; i--) begin DIR = i[0]; send_bit(d3[i]); end
        chk("t3_q", 32'(Q), 32'hA6); chk("t3_valid", 32'(VALID), 1);
        idle(1);
        chk("t3_valid_drop", 32'(VALID), 0);

        // 4: back-pressure and overrun
        DIR = 0; READY = 0;
        send_nib(4'b1101); send_nib(4'hA); send_nib(4'h6);
        chk("t4_q1", 32'(Q), 32'hA6); chk("t4_ovr0", 32'(OVERRUN), 0);
        send_nib(4'b1101); send_nib(4'h3); send_nib(4'hC);
        chk("t4_q", 32'(Q), 32'hA6); chk("t4_valid", 32'(VALID), 1);
        chk("t4_overrun", 32'(OVERRUN), 1);
        READY = 1;
        idle(1);
        chk("t4_valid_drop", 32'(VALID), 0); chk("t4_ovr_sticky", 32'(OVERRUN), 1);

        // 5: gaps of ENB=0 between every bit
        s5 = 12'b1101_1010_0110;
        for (int i = 11; i >= 0; i--) begin
            send_bit(s5[i]);
            if (i != 0) idle(3);
        end
        chk("t5_q", 32'(Q), 32'hA6); chk("t5_valid", 32'(VALID), 1);
        idle(1);
        chk("t5_valid_drop", 32'(VALID), 0);

        // 6: reset mid-frame, transition count, false sync
        send_nib(4'b1101);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        RESET_L = 0;
        @(negedge CLK);
        RESET_L = 1;
        chk("t6_locked", 32'(LOCKED), 0); chk("t6_valid", 32'(VALID), 0);
        chk("t6_ovr_clr", 32'(OVERRUN), 0);
        idle(3);
        chk("t6_no_valid", 32'(VALID), 0);
        send_nib(4'b1101);
        chk("t6_trans", 32'(TRANS_CNT), 2); chk("t6_relock", 32'(LOCKED), 1);
        send_nib(4'h0); send_nib(4'h0);
        chk("t6_q00", 32'(Q), 0); chk("t6_v00", 32'(VALID), 1);
        idle(1);
        send_nib(4'b1100);
        send_bit(1); send_bit(1); send_bit(0);
        chk("t6_no_false_lock", 32'(LOCKED), 0);
        send_bit(1);
        chk("t6_lock8", 32'(LOCKED), 1);
        send_nib(4'h5); send_nib(4'hA);
        chk("t6_q5a", 32'(Q), 32'h5A); chk("t6_v5a", 32'(VALID), 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
